// File: rtl/board_state_if.sv
// Move-request bus from the column calculator into the board state holder.
interface board_state_if;
    logic       add;
    logic [1:0] c_register;
    logic [4:0] column_position;
    logic       hold;

    modport master (output add, output c_register, output column_position, output hold);
    modport slave  (input  add, input  c_register, input  column_position, input  hold);
endinterface

// File: rtl/board_state.sv
// Connect4 4x4 board holder: commits one token per add request, alternates players,
// and tracks per-column fill counters fed back to the column calculator.
module board_state (
    input  logic             clk,
    input  logic             rst,
    board_state_if.slave     req,
    output logic [2:0]       counter_0,
    output logic [2:0]       counter_1,
    output logic [2:0]       counter_2,
    output logic [2:0]       counter_3,
    output logic [31:0]      board,
    output logic [1:0]       current_player,
    output logic [4:0]       move_count,
    output logic             board_full,
    output logic             move_done,
    output logic             move_reject
);
    localparam int unsigned NUM_COLS  = 4;
    localparam int unsigned NUM_ROWS  = 4;
    localparam int unsigned NUM_CELLS = NUM_COLS * NUM_ROWS;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic {IDLE, WAIT_RELEASE} state_t;

    state_t           state;
    logic [CNT_W-1:0] col_cnt [NUM_COLS];
    logic [CNT_W-1:0] sel_cnt_c;
    logic             req_valid_c;
    logic [4:0]       cell_bit_c;

    assign counter_0 = col_cnt[0];
    assign counter_1 = col_cnt[1];
    assign counter_2 = col_cnt[2];
    assign counter_3 = col_cnt[3];

    assign board_full = (move_count == 5'(NUM_CELLS));
    assign sel_cnt_c  = col_cnt[req.c_register];
    assign cell_bit_c = {req.column_position[3:0], 1'b0};

    // Target must be the next free row of the named column on a non-full board.
    assign req_valid_c = (req.column_position != 5'd31)
                      && (req.column_position[1:0] == req.c_register)
                      && (req.column_position[4:2] == sel_cnt_c)
                      && (sel_cnt_c < CNT_W'(NUM_ROWS))
                      && !board_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            board          <= '0;
            move_count     <= '0;
            current_player <= 2'b01;
            move_done      <= 1'b0;
            move_reject    <= 1'b0;
            for (int unsigned i = 0; i < NUM_COLS; i++) begin
                col_cnt[i] <= '0;
            end
        end else begin
            move_done   <= 1'b0;
            move_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.add && !req.hold) begin
                        if (req_valid_c) begin
                            board[cell_bit_c +: 2]   <= current_player;
                            col_cnt[req.c_register] <= sel_cnt_c + CNT_W'(1);
                            move_count              <= move_count + 5'd1;
                            current_player          <= ~current_player;
                            move_done               <= 1'b1;
                        end else begin
                            move_reject <= 1'b1;
                        end
                        state <= WAIT_RELEASE;
                    end
                end
                // The calculator holds add while the key is down; wait for it to drop.
                WAIT_RELEASE: begin
                    if (!req.add) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_state.sv
// Randomized self-checking bench for board_state against a cell-array game model.
module tb_board_state;
    logic        clk;
    logic        rst;
    logic [2:0]  counter_0, counter_1, counter_2, counter_3;
    logic [31:0] board;
    logic [1:0]  current_player;
    logic [4:0]  move_count;
    logic        board_full;
    logic        move_done;
    logic        move_reject;

    board_state_if bus();

    board_state dut (
        .clk            (clk),
        .rst            (rst),
        .req            (bus),
        .counter_0      (counter_0),
        .counter_1      (counter_1),
        .counter_2      (counter_2),
        .counter_3      (counter_3),
        .board          (board),
        .current_player (current_player),
        .move_count     (move_count),
        .board_full     (board_full),
        .move_done      (move_done),
        .move_reject    (move_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Game model: one entry per cell (0 empty, 1/2 player), column heights, turn.
    int mcell [16];
    int mh [4];
    int mplayer;
    int mmoves;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mcell[i] = 0;
        for (int i = 0; i < 4; i++) mh[i] = 0;
        mplayer = 1;
        mmoves  = 0;
    endfunction

    function automatic bit model_move(input int col, input int pos);
        if (mmoves < 16 && mh[col] < 4 && pos == col + 4 * mh[col]) begin
            mcell[pos] = mplayer;
            mh[col]    = mh[col] + 1;
            mmoves     = mmoves + 1;
            mplayer    = 3 - mplayer;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_board();
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[2*i +: 2] = 2'(mcell[i]);
        return b;
    endfunction

    function automatic logic [11:0] exp_counters();
        return {3'(mh[3]), 3'(mh[2]), 3'(mh[1]), 3'(mh[0])};
    endfunction

    // Drive one request for hi_cycles edges, release it, and tally pulses seen.
    task automatic send(input int col, input int pos, input bit h, input int hi_cycles,
                        output int dones, output int rejs);
        dones = 0;
        rejs  = 0;
        @(negedge clk);
        bus.add             = 1'b1;
        bus.c_register      = 2'(col);
        bus.column_position = 5'(pos);
        bus.hold            = h;
        for (int i = 0; i < hi_cycles; i++) begin
            @(posedge clk); #1;
            dones += int'(move_done);
            rejs  += int'(move_reject);
        end
        @(negedge clk);
        bus.add  = 1'b0;
        bus.hold = 1'b0;
        @(posedge clk); #1;
        dones += int'(move_done);
        rejs  += int'(move_reject);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.add = 1'b0;
        bus.hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if (board !== 32'h0) begin fails++; $display("FAIL reset_board got %h want 0", board); end
        tests++;
        if ({counter_3, counter_2, counter_1, counter_0} !== 12'h0) begin
            fails++; $display("FAIL reset_counters got %h want 0", {counter_3, counter_2, counter_1, counter_0});
        end
        tests++;
        if (current_player !== 2'b01 || move_count !== 5'd0 || board_full !== 1'b0) begin
            fails++; $display("FAIL reset_misc got player=%b count=%0d full=%b want 01/0/0",
                              current_player, move_count, board_full);
        end
        tests++;
        if (move_done !== 1'b0 || move_reject !== 1'b0) begin
            fails++; $display("FAIL reset_pulses got done=%b rej=%b want 0/0", move_done, move_reject);
        end
    endtask

    task automatic test_first_move();
        int d, r;
        do_reset();
        send(2, 2, 1'b0, 5, d, r);
        void'(model_move(2, 2));
        tests++;
        if (d !== 1 || r !== 0) begin fails++; $display("FAIL first_pulses got done=%0d rej=%0d want 1/0", d, r); end
        tests++;
        if (board[5:4] !== 2'b01 || board !== exp_board()) begin
            fails++; $display("FAIL first_board got %h want %h", board, exp_board());
        end
        tests++;
        if (counter_2 !== 3'd1 || current_player !== 2'b10 || move_count !== 5'd1) begin
            fails++; $display("FAIL first_state got cnt2=%0d player=%b count=%0d want 1/10/1",
                              counter_2, current_player, move_count);
        end
    endtask

    task automatic test_column_fill();
        int d, r;
        logic [31:0] snap;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(0, 4 * k, 1'b0, 1 + int'($urandom_range(0, 3)), d, r);
            void'(model_move(0, 4 * k));
            tests++;
            if (d !== 1 || r !== 0 || board[8*k +: 2] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL fill_move%0d got done=%0d rej=%0d cell=%b", k, d, r, board[8*k +: 2]);
            end
        end
        tests++;
        if (counter_0 !== 3'd4 || board !== exp_board()) begin
            fails++; $display("FAIL fill_col got cnt0=%0d board=%h want 4/%h", counter_0, board, exp_board());
        end
        snap = board;
        send(0, 16, 1'b0, 2, d, r);
        tests++;
        if (d !== 0 || r !== 1 || board !== snap || counter_0 !== 3'd4 || move_count !== 5'd4) begin
            fails++; $display("FAIL fill_overflow got done=%0d rej=%0d board=%h cnt0=%0d", d, r, board, counter_0);
        end
    endtask

    task automatic test_inconsistency();
        int d, r;
        logic [31:0] snap;
        snap = board;
        send(1, 6, 1'b0, 3, d, r);
        tests++;
        if (d !== 0 || r !== 1 || board !== snap || counter_1 !== 3'd0) begin
            fails++; $display("FAIL incons_col got done=%0d rej=%0d board=%h want 0/1/%h", d, r, board, snap);
        end
        send(int'($urandom_range(1, 3)), 31, 1'b0, 1, d, r);
        tests++;
        if (d !== 0 || r !== 1 || board !== snap || move_count !== 5'(mmoves)) begin
            fails++; $display("FAIL incons_31 got done=%0d rej=%0d count=%0d want 0/1/%0d", d, r, move_count, mmoves);
        end
    endtask

    task automatic test_full_board();
        int d, r, col, pos, iter;
        bit ok;
        do_reset();
        iter = 0;
        while (mmoves < 16 && iter < 300) begin
            iter++;
            if ($urandom_range(0, 3) == 0) begin
                col = int'($urandom_range(0, 3));
                pos = int'($urandom_range(0, 31));
            end else begin
                do col = int'($urandom_range(0, 3)); while (mh[col] >= 4);
                pos = col + 4 * mh[col];
            end
            send(col, pos, 1'b0, 1 + int'($urandom_range(0, 2)), d, r);
            ok = model_move(col, pos);
            tests++;
            if (d !== int'(ok) || r !== int'(!ok) || board !== exp_board()
                || {counter_3, counter_2, counter_1, counter_0} !== exp_counters()
                || current_player !== 2'(mplayer) || move_count !== 5'(mmoves)) begin
                fails++; $display("FAIL full_step col=%0d pos=%0d got done=%0d rej=%0d board=%h cnt=%h want %0d/%0d/%h/%h",
                                  col, pos, d, r, board, {counter_3, counter_2, counter_1, counter_0},
                                  ok, !ok, exp_board(), exp_counters());
            end
        end
        tests++;
        if (mmoves != 16 || board_full !== 1'b1 || move_count !== 5'd16) begin
            fails++; $display("FAIL full_flag got full=%b count=%0d want 1/16", board_full, move_count);
        end
        col = int'($urandom_range(0, 3));
        send(col, col + 12, 1'b0, 1, d, r);
        tests++;
        if (d !== 0 || r !== 1 || board !== exp_board()) begin
            fails++; $display("FAIL full_extra got done=%0d rej=%0d want 0/1", d, r);
        end
    endtask

    task automatic test_hold_and_reset();
        int d, r;
        do_reset();
        send(3, 3, 1'b1, 3, d, r);
        tests++;
        if (d !== 0 || r !== 0 || board !== 32'h0 || move_count !== 5'd0) begin
            fails++; $display("FAIL hold_block got done=%0d rej=%0d board=%h want 0/0/0", d, r, board);
        end
        send(3, 3, 1'b0, 1, d, r);
        void'(model_move(3, 3));
        tests++;
        if (d !== 1 || board !== exp_board() || counter_3 !== 3'd1) begin
            fails++; $display("FAIL hold_after got done=%0d board=%h want 1/%h", d, board, exp_board());
        end
        // Reset on the same edge as a valid request.
        @(negedge clk);
        rst = 1'b1;
        bus.add = 1'b1;
        bus.c_register = 2'd1;
        bus.column_position = 5'd1;
        @(posedge clk); #1;
        model_reset();
        tests++;
        if (move_done !== 1'b0 || board !== 32'h0 || move_count !== 5'd0 || current_player !== 2'b01) begin
            fails++; $display("FAIL rst_overlap got done=%b board=%h count=%0d player=%b", move_done, board,
                              move_count, current_player);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.add = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (move_done !== 1'b0 || move_reject !== 1'b0 || counter_1 !== 3'd0) begin
            fails++; $display("FAIL rst_after got done=%b rej=%b cnt1=%0d want 0/0/0", move_done, move_reject, counter_1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.add = 1'b0;
        bus.c_register = 2'd0;
        bus.column_position = 5'd0;
        bus.hold = 1'b0;
        model_reset();
        test_reset();
        test_first_move();
        test_column_fill();
        test_inconsistency();
        test_full_board();
        test_hold_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/board_state.md
# board_state

Holds the Connect4 game state downstream of the column calculator: consumes its `add` / `c_register` / `column_position` move requests, commits one token per request into a 4x4 board and alternates the current player. It maintains the per-column fill counters `counter_0..counter_3` that feed back into the calculator, and exposes the board to the display and win-check logic.

## Interface
- No parameters; the board is fixed at 4 columns x 4 rows, 16 cells.
- `clk` input 1: single system clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `add` input 1: move request from the column calculator.
- `c_register` input 2: column index of the request, 0..3.
- `column_position` input 5: target cell index `row*4 + column`; 31 means invalid.
- `hold` input 1: freeze; while 1, no move is accepted (asserted by win logic).
- `counter_0`..`counter_3` output 3 each: tokens in column 0..3, range 0..4.
- `board` output 32: cell i occupies bits [2i+1:2i]; 00 = empty, 01 = player 1, 10 = player 2.
- `current_player` output 2: player who places the next token, 01 or 10.
- `move_count` output 5: total tokens placed, 0..16.
- `board_full` output 1: high when `move_count` == 16.
- `move_done` output 1: one-cycle pulse per committed move.
- `move_reject` output 1: one-cycle pulse per refused request.

## Operation
- **Reset values:**
  - `board` = 0; all counters = 0; `move_count` = 0.
  - `current_player` = 01.
  - `move_done` = 0; `move_reject` = 0; `board_full` = 0.
  - FSM = IDLE.
- **FSM states:** IDLE and WAIT_RELEASE.
- **IDLE, `add` = 0 or `hold` = 1:** no action.
- **IDLE, `add` = 1 and `hold` = 0:** the request is valid only when all of the following hold:
  - `column_position` != 31;
  - `column_position[1:0]` == `c_register`;
  - `column_position[4:2]` == the counter of column `c_register`;
  - that counter < 4;
  - `board_full` = 0.
- **Valid request (commit):**
  - Write `current_player` into the addressed cell.
  - Increment that column's counter and `move_count`.
  - Toggle `current_player` (01 <-> 10).
  - Pulse `move_done`.
  - Go to WAIT_RELEASE.
- **Invalid request:**
  - State is unchanged.
  - Pulse `move_reject`.
  - Go to WAIT_RELEASE.
- **WAIT_RELEASE:**
  - Every `add` is ignored with no pulse; this is needed because the calculator keeps `add` high while the key is held.
  - Return to IDLE on the first cycle `add` is sampled 0.
- **`hold` = 1:** blocks acceptance in IDLE; the WAIT_RELEASE exit still tracks `add`.
- **Counter width:** counters saturate by rule, not by wrap; an increment past 4 never occurs.
- **`board_full`:** derived combinationally from `move_count`.

## Timing
- **Request latency:** `add` sampled high at edge N (IDLE) -> `board`, counter, `move_count` and `current_player` are updated after edge N.
- **Pulses:** `move_done` or `move_reject` is high for exactly the cycle following edge N.
- **Feedback:** the updated counter is visible to the calculator one cycle after commit. Any recomputed `add` in that cycle falls into WAIT_RELEASE and is ignored.
- **Minimum move spacing:** 3 cycles (accept, release-low sample, next accept).
- **`rst` during WAIT_RELEASE or a pulse cycle:** the reset values win on that edge and no pulse follows.
- **`rst` together with `add`:** reset wins; the move is lost.
- **`hold` rising on the same edge as `add`:** the move is not accepted.

## Test plan
- **Reset:** `rst` for 2 cycles -> `board` = 0, counters 0, `current_player` = 01, no pulses.
- **First move:**
  - Stimulus: `add` = 1, `c_register` = 2, `column_position` = 2, held 5 cycles, then released.
  - Required response: exactly one `move_done`; `board[5:4]` = 01; `counter_2` = 1; `current_player` = 10; `move_count` = 1.
- **Column fill:**
  - Stimulus: 4 separate requests in column 0 at positions 0, 4, 8, 12.
  - Required response: cells alternate 01/10/01/10; `counter_0` = 4.
  - Then a 5th request with position 16 -> `move_reject`, no state change.
- **Inconsistency:**
  - Stimulus: `add` = 1, `c_register` = 1, `column_position` = 6 (column bits 10).
  - Required response: `move_reject`, board unchanged.
  - Also `column_position` = 31 -> `move_reject`.
- **Full board:**
  - Stimulus: 16 legal moves.
  - Required response: `board_full` = 1 and `move_count` = 16; a further request -> `move_reject`.
- **Hold and reset overlap:**
  - `hold` = 1 with a valid request -> no pulse, no change.
  - `rst` asserted on the edge that samples a valid `add` -> reset values, no `move_done`.
